// File: rtl/risc16_decode_stage_pkg.sv
// rtl/risc16_decode_stage_pkg.sv - RiSC-16 decode stage types, opcodes and ALU function codes
package risc16_decode_stage_pkg;

  localparam int WORD_LENGTH   = 16;
  localparam int REG_ADDR_LEN  = 3;
  localparam int NUM_REGS      = 8;
  localparam int ALU_FUNCT_LEN = 2;

  localparam logic [ALU_FUNCT_LEN-1:0] ALU_ADD   = 2'd0;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_NAND  = 2'd1;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASS1 = 2'd2;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_EQ    = 2'd3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_t;

  typedef logic [WORD_LENGTH-1:0]  word_t;
  typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

  typedef struct packed {
    word_t                    src1;
    word_t                    src2;
    logic [ALU_FUNCT_LEN-1:0] funct;
    opcode_t                  op;
    word_t                    aux;
    word_t                    imm;
    word_t                    pc;
    reg_addr_t                dest;
    logic                     wb_en;
  } ex_bundle_t;

  function automatic word_t sext7(input logic [6:0] v);
    return {{(WORD_LENGTH-7){v[6]}}, v};
  endfunction

endpackage

// File: rtl/risc16_decode_stage_if.sv
// rtl/risc16_decode_stage_if.sv - instruction, execute-bundle and write-back signals of the decode stage
interface risc16_decode_stage_if;
  import risc16_decode_stage_pkg::*;

  word_t                    instr;
  word_t                    instr_pc;
  logic                     instr_valid;
  logic                     instr_ready;
  word_t                    ex_src1;
  word_t                    ex_src2;
  logic [ALU_FUNCT_LEN-1:0] ex_funct;
  logic [2:0]               ex_op;
  word_t                    ex_aux;
  word_t                    ex_imm;
  word_t                    ex_pc;
  reg_addr_t                ex_dest;
  logic                     ex_wb_en;
  logic                     ex_valid;
  logic                     ex_ready;
  logic                     wb_en;
  reg_addr_t                wb_addr;
  word_t                    wb_data;
  logic                     flush;

  // slave: the decode stage itself; master: fetch, execute and write-back around it
  modport slave (
    input  instr, instr_pc, instr_valid, ex_ready, wb_en, wb_addr, wb_data, flush,
    output instr_ready, ex_src1, ex_src2, ex_funct, ex_op, ex_aux, ex_imm, ex_pc,
           ex_dest, ex_wb_en, ex_valid
  );

  modport master (
    output instr, instr_pc, instr_valid, ex_ready, wb_en, wb_addr, wb_data, flush,
    input  instr_ready, ex_src1, ex_src2, ex_funct, ex_op, ex_aux, ex_imm, ex_pc,
           ex_dest, ex_wb_en, ex_valid
  );

endinterface

// File: rtl/risc16_regfile.sv
// rtl/risc16_regfile.sv - 8x16 register file, two read ports with write bypass, r0 reads zero
module risc16_regfile
  import risc16_decode_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rd_a_addr,
  output word_t     rd_a_data,
  input  reg_addr_t rd_b_addr,
  output word_t     rd_b_data,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  word_t     wr_data
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    rd_a_data = regs_q[rd_a_addr];
    if (wr_en && wr_addr == rd_a_addr) rd_a_data = wr_data;
    if (rd_a_addr == '0)               rd_a_data = '0;
    rd_b_data = regs_q[rd_b_addr];
    if (wr_en && wr_addr == rd_b_addr) rd_b_data = wr_data;
    if (rd_b_addr == '0)               rd_b_data = '0;
  end

endmodule

// File: rtl/risc16_decode_stage.sv
// rtl/risc16_decode_stage.sv - RiSC-16 decode/operand fetch with scoreboard hazard stall and flush
module risc16_decode_stage
  import risc16_decode_stage_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  risc16_decode_stage_if.slave bus
);

  opcode_t    op;
  reg_addr_t  ra, rb, rc;
  reg_addr_t  rd_a_addr, rd_b_addr;
  word_t      rd_a_data, rd_b_data;
  word_t      simm;
  logic       uses_a, uses_b, writes_rd;
  logic       hazard, accept;
  logic [NUM_REGS-1:0] wb_clear, blocked;

  ex_bundle_t          nxt;
  ex_bundle_t          ex_q, ex_d;
  logic                ex_valid_q, ex_valid_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;

  assign op   = opcode_t'(bus.instr[15:13]);
  assign ra   = bus.instr[12:10];
  assign rb   = bus.instr[9:7];
  assign rc   = bus.instr[2:0];
  assign simm = sext7(bus.instr[6:0]);

  assign rd_a_addr = (op == OP_BEQ) ? ra : rb;
  assign rd_b_addr = (op == OP_ADD || op == OP_NAND) ? rc : (op == OP_SW) ? ra : rb;
  assign uses_a    = (op != OP_LUI);
  assign uses_b    = (op == OP_ADD) || (op == OP_NAND) || (op == OP_SW) || (op == OP_BEQ);
  assign writes_rd = (op != OP_SW) && (op != OP_BEQ) && (ra != '0);

  risc16_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (rd_a_addr),
    .rd_a_data (rd_a_data),
    .rd_b_addr (rd_b_addr),
    .rd_b_data (rd_b_data),
    .wr_en     (bus.wb_en),
    .wr_addr   (bus.wb_addr),
    .wr_data   (bus.wb_data)
  );

  // A pending register being written back this cycle is satisfied by the read bypass.
  assign wb_clear = bus.wb_en ? (NUM_REGS'(1) << bus.wb_addr) : '0;
  assign blocked  = sb_q & ~wb_clear;
  assign hazard   = (uses_a && blocked[rd_a_addr]) || (uses_b && blocked[rd_b_addr]) ||
                    (writes_rd && blocked[ra]);

  assign bus.instr_ready = ~rst & ~bus.flush & ~hazard & (~ex_valid_q | bus.ex_ready);
  assign accept          = bus.instr_valid & bus.instr_ready;

  always_comb begin
    nxt       = '0;
    nxt.op    = op;
    nxt.pc    = bus.instr_pc;
    nxt.dest  = ra;
    nxt.wb_en = writes_rd;
    case (op)
      OP_ADD, OP_NAND: begin
        nxt.src1  = rd_a_data;
        nxt.src2  = rd_b_data;
        nxt.funct = (op == OP_NAND) ? ALU_NAND : ALU_ADD;
      end
      OP_ADDI, OP_LW: begin
        nxt.src1  = rd_a_data;
        nxt.src2  = simm;
        nxt.funct = ALU_ADD;
      end
      OP_LUI: begin
        nxt.src1  = {bus.instr[9:0], 6'b0};
        nxt.funct = ALU_PASS1;
      end
      OP_SW: begin
        nxt.src1  = rd_a_data;
        nxt.src2  = simm;
        nxt.funct = ALU_ADD;
        nxt.aux   = rd_b_data;
      end
      OP_BEQ: begin
        nxt.src1  = rd_a_data;
        nxt.src2  = rd_b_data;
        nxt.funct = ALU_EQ;
        nxt.imm   = simm;
      end
      default: begin
        nxt.src1  = bus.instr_pc + 16'd1;
        nxt.funct = ALU_PASS1;
        nxt.aux   = rd_b_data;
      end
    endcase
  end

  // Set after clear: a same-cycle write-back to the new dest leaves it pending for the new writer.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    sb_d       = sb_q & ~wb_clear;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
      if (ex_valid_q && !bus.ex_ready && ex_q.wb_en) sb_d[ex_q.dest] = 1'b0;
    end else if (accept) begin
      ex_d       = nxt;
      ex_valid_d = 1'b1;
      if (nxt.wb_en) sb_d[nxt.dest] = 1'b1;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      sb_q       <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      sb_q       <= sb_d;
    end
  end

  assign bus.ex_src1  = ex_q.src1;
  assign bus.ex_src2  = ex_q.src2;
  assign bus.ex_funct = ex_q.funct;
  assign bus.ex_op    = ex_q.op;
  assign bus.ex_aux   = ex_q.aux;
  assign bus.ex_imm   = ex_q.imm;
  assign bus.ex_pc    = ex_q.pc;
  assign bus.ex_dest  = ex_q.dest;
  assign bus.ex_wb_en = ex_q.wb_en;
  assign bus.ex_valid = ex_valid_q;

endmodule

// File: tb/tb_risc16_decode_stage.sv
// tb/tb_risc16_decode_stage.sv - directed and randomized checks of the RiSC-16 decode stage
module tb_risc16_decode_stage;
  import risc16_decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  risc16_decode_stage_if bus();
  risc16_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: architectural registers, pending-write flags and the expected ex bundle.
  logic [15:0] m_regs [8];
  logic        m_pend [8];
  logic        m_valid;
  logic [88:0] m_ex;

  function automatic logic [88:0] obs();
    return {bus.ex_src1, bus.ex_src2, bus.ex_funct, bus.ex_op, bus.ex_aux, bus.ex_imm,
            bus.ex_pc, bus.ex_dest, bus.ex_wb_en};
  endfunction

  function automatic logic [15:0] m_rd(logic [2:0] r);
    if (r == 3'd0) return 16'h0;
    if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return m_regs[r];
  endfunction

  function automatic logic m_busy(logic [2:0] r);
    return (r != 3'd0) && m_pend[r] && !(bus.wb_en && bus.wb_addr == r);
  endfunction

  function automatic logic m_decode(output logic [88:0] b);
    logic [2:0]  op, ra, rb, rc;
    logic [15:0] s, s1, s2, aux, imm;
    logic [1:0]  f;
    logic        wb, st;
    op = bus.instr[15:13]; ra = bus.instr[12:10]; rb = bus.instr[9:7]; rc = bus.instr[2:0];
    s  = bus.instr[6] ? 16'(bus.instr[6:0]) - 16'd128 : 16'(bus.instr[6:0]);
    s1 = 16'h0; s2 = 16'h0; aux = 16'h0; imm = 16'h0; f = ALU_ADD; wb = 1'b1; st = 1'b0;
    case (op)
      3'd0, 3'd2: begin
        s1 = m_rd(rb); s2 = m_rd(rc); f = (op == 3'd2) ? ALU_NAND : ALU_ADD;
        st = m_busy(rb) || m_busy(rc);
      end
      3'd1, 3'd5: begin s1 = m_rd(rb); s2 = s; st = m_busy(rb); end
      3'd3:       begin s1 = 16'(bus.instr[9:0]) * 16'd64; f = ALU_PASS1; end
      3'd4: begin
        s1 = m_rd(rb); s2 = s; aux = m_rd(ra); wb = 1'b0; st = m_busy(rb) || m_busy(ra);
      end
      3'd6: begin
        s1 = m_rd(ra); s2 = m_rd(rb); f = ALU_EQ; imm = s; wb = 1'b0;
        st = m_busy(ra) || m_busy(rb);
      end
      default: begin
        s1 = bus.instr_pc + 16'd1; f = ALU_PASS1; aux = m_rd(rb); st = m_busy(rb);
      end
    endcase
    if (ra == 3'd0) wb = 1'b0;
    if (wb && m_busy(ra)) st = 1'b1;
    b = {s1, s2, f, op, aux, imm, bus.instr_pc, ra, wb};
    return st;
  endfunction

  function automatic logic m_ready();
    logic [88:0] b;
    logic        st;
    st = m_decode(b);
    return !rst && !bus.flush && !st && (!m_valid || bus.ex_ready);
  endfunction

  task automatic m_step();
    logic [88:0] b;
    logic        acc;
    acc = bus.instr_valid && m_ready();
    void'(m_decode(b));
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 16'h0; m_pend[i] = 1'b0; end
      m_valid = 1'b0; m_ex = '0;
      return;
    end
    if (bus.wb_en) begin
      if (bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
      m_pend[bus.wb_addr] = 1'b0;
    end
    if (bus.flush) begin
      if (m_valid && !bus.ex_ready && m_ex[0]) m_pend[m_ex[3:1]] = 1'b0;
      m_valid = 1'b0;
    end else if (acc) begin
      m_ex = b; m_valid = 1'b1;
      if (b[0]) m_pend[b[3:1]] = 1'b1;
    end else if (bus.ex_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0; bus.wb_en = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    bus.instr = 16'h0C82; bus.instr_pc = 16'h0; bus.instr_valid = 1'b1;
    bus.wb_addr = 3'd0; bus.wb_data = 16'h0;
    #1;
    tests_run++;
    if (bus.instr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 0", bus.instr_ready);
    end
    tick(); tick();
    tests_run++;
    if ({bus.ex_valid, obs()} !== 90'h0) begin
      tests_failed++; $display("FAIL reset_ex: got %h expected 0", {bus.ex_valid, obs()});
    end
    rst = 1'b0; #1;
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_ready: got %b expected 1", bus.instr_ready);
    end
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_add_issue();
    idle();
    wb(3'd1, 16'h0066);
    wb(3'd2, 16'h00CD);
    bus.instr = 16'h0C82; bus.instr_pc = 16'h0010; bus.instr_valid = 1'b1; #1;
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL add_ready: got %b expected 1", bus.instr_ready);
    end
    tick();
    tests_run++;
    if ({bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_funct, bus.ex_dest, bus.ex_wb_en} !==
        {1'b1, 16'h0066, 16'h00CD, ALU_ADD, 3'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL add_issue: got v=%b s1=%h s2=%h f=%0d d=%0d w=%b expected v=1 s1=0066 s2=00cd f=%0d d=3 w=1",
               bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_funct, bus.ex_dest, bus.ex_wb_en, ALU_ADD);
    end
  endtask

  task automatic test_raw_stall();
    bus.instr = 16'h31FF; bus.instr_pc = 16'h0011; bus.ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus.instr_ready !== 1'b0) begin
        tests_failed++; $display("FAIL raw_stall[%0d]: got ready %b expected 0", i, bus.instr_ready);
      end
      tick();
    end
    tests_run++;
    if (bus.ex_valid !== 1'b0) begin
      tests_failed++; $display("FAIL raw_drain: got ex_valid %b expected 0", bus.ex_valid);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'h0133; #1;
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL raw_release: got ready %b expected 1", bus.instr_ready);
    end
    tick();
    bus.wb_en = 1'b0;
    tests_run++;
    if ({bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_dest} !== {1'b1, 16'h0133, 16'hFFFF, 3'd4}) begin
      tests_failed++;
      $display("FAIL raw_bypass: got v=%b s1=%h s2=%h d=%0d expected v=1 s1=0133 s2=ffff d=4",
               bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_dest);
    end
  endtask

  task automatic test_hold_lui();
    logic [88:0] held;
    held = {16'h0133, 16'hFFFF, ALU_ADD, 3'd1, 16'h0, 16'h0, 16'h0011, 3'd4, 1'b1};
    bus.ex_ready = 1'b0; bus.instr = 16'h77FF; bus.instr_pc = 16'h0012; bus.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus.instr_ready !== 1'b0) begin
        tests_failed++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, bus.instr_ready);
      end
      tick();
      tests_run++;
      if ({bus.ex_valid, obs()} !== {1'b1, held}) begin
        tests_failed++; $display("FAIL hold_bundle[%0d]: got %h expected %h", i, {bus.ex_valid, obs()}, {1'b1, held});
      end
    end
    bus.ex_ready = 1'b1; #1;
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL hold_release: got %b expected 1", bus.instr_ready);
    end
    tick();
    tests_run++;
    if ({bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_funct, bus.ex_dest, bus.ex_wb_en} !==
        {1'b1, 16'hFFC0, 16'h0000, ALU_PASS1, 3'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL lui: got s1=%h s2=%h f=%0d d=%0d w=%b expected s1=ffc0 s2=0000 f=%0d d=5 w=1",
               bus.ex_src1, bus.ex_src2, bus.ex_funct, bus.ex_dest, bus.ex_wb_en, ALU_PASS1);
    end
    bus.instr_valid = 1'b0;
    wb(3'd4, 16'h0444);
    wb(3'd5, 16'h0555);
  endtask

  task automatic test_r0_dest();
    bus.instr = 16'h0082; bus.instr_pc = 16'h0020; bus.instr_valid = 1'b1; bus.ex_ready = 1'b1;
    tick();
    tests_run++;
    if ({bus.ex_valid, bus.ex_wb_en, bus.ex_dest, bus.ex_src1} !== {1'b1, 1'b0, 3'd0, 16'h0066}) begin
      tests_failed++;
      $display("FAIL r0_dest: got v=%b w=%b d=%0d s1=%h expected v=1 w=0 d=0 s1=0066",
               bus.ex_valid, bus.ex_wb_en, bus.ex_dest, bus.ex_src1);
    end
    bus.instr = 16'h3801; #1;
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL r0_no_stall: got %b expected 1", bus.instr_ready);
    end
    tick();
    tests_run++;
    if ({bus.ex_src1, bus.ex_src2, bus.ex_dest} !== {16'h0000, 16'h0001, 3'd6}) begin
      tests_failed++; $display("FAIL r0_read: got s1=%h s2=%h d=%0d expected s1=0000 s2=0001 d=6",
                               bus.ex_src1, bus.ex_src2, bus.ex_dest);
    end
    bus.instr = 16'h1C00; bus.wb_en = 1'b1; bus.wb_addr = 3'd0; bus.wb_data = 16'h1234;
    tick();
    bus.wb_en = 1'b0;
    tests_run++;
    if ({bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_dest} !== {1'b1, 16'h0000, 16'h0000, 3'd7}) begin
      tests_failed++; $display("FAIL r0_write_ignored: got v=%b s1=%h s2=%h d=%0d expected v=1 s1=0 s2=0 d=7",
                               bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_dest);
    end
    bus.instr_valid = 1'b0;
    wb(3'd6, 16'h0666);
    wb(3'd7, 16'h0777);
  endtask

  task automatic test_flush();
    bus.instr = 16'h0C82; bus.instr_pc = 16'h0030; bus.instr_valid = 1'b1; bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0; bus.flush = 1'b1; bus.instr = 16'h31FF; bus.instr_pc = 16'h0031; #1;
    tests_run++;
    if (bus.instr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL flush_no_accept: got %b expected 0", bus.instr_ready);
    end
    tick();
    bus.flush = 1'b0; #1;
    tests_run++;
    if ({bus.ex_valid, bus.instr_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL flush_cancel: got valid=%b ready=%b expected valid=0 ready=1",
                               bus.ex_valid, bus.instr_ready);
    end
    bus.ex_ready = 1'b1;
    tick();
    tests_run++;
    if ({bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_dest} !== {1'b1, 16'h0133, 16'hFFFF, 3'd4}) begin
      tests_failed++; $display("FAIL flush_next: got v=%b s1=%h s2=%h d=%0d expected v=1 s1=0133 s2=ffff d=4",
                               bus.ex_valid, bus.ex_src1, bus.ex_src2, bus.ex_dest);
    end
    bus.instr_valid = 1'b0;
    wb(3'd4, 16'h0444);
  endtask

  task automatic test_random();
    logic [2:0] pend_list [$];
    for (int i = 0; i < 1500; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.instr       = 16'($urandom);
      bus.instr_pc    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.ex_ready    = ($urandom_range(0, 3) != 0);
      bus.flush       = ($urandom_range(0, 15) == 0);
      bus.wb_en       = ($urandom_range(0, 1) == 1);
      bus.wb_data     = 16'($urandom);
      pend_list.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r]) pend_list.push_back(3'(r));
      if (pend_list.size() != 0 && $urandom_range(0, 3) != 0)
        bus.wb_addr = pend_list[$urandom_range(0, pend_list.size() - 1)];
      else
        bus.wb_addr = 3'($urandom_range(0, 7));
      #1;
      tests_run++;
      if (bus.instr_ready !== m_ready()) begin
        tests_failed++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, bus.instr_ready, m_ready());
      end
      tick();
      tests_run++;
      if (bus.ex_valid !== m_valid) begin
        tests_failed++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.ex_valid, m_valid);
      end
      if (m_valid) begin
        tests_run++;
        if (obs() !== m_ex) begin
          tests_failed++; $display("FAIL rand_bundle[%0d]: got %h expected %h", i, obs(), m_ex);
        end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_add_issue();
    test_raw_stall();
    test_hold_lui();
    test_r0_dest();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
